// File: rtl/pipelined_xor_accum_pkg.sv
// Shared mode encodings and default sizing for the pipelined XOR accumulator.
package pipelined_xor_accum_pkg;

  typedef enum logic {
    MODE_XOR = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 14;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/pipelined_xor_accum_xor_stage.sv
// Parametrised bitwise XOR of two operand vectors (purely combinational).
module xor_stage
  import pipelined_xor_accum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] x_o
);

  assign x_o = a_i ^ b_i;

endmodule

// File: rtl/pipelined_xor_accum.sv
// Two-stage XOR pipeline: pass-through XOR results or fold a frame of beats
// into a single syndrome, with valid/ready flow control on both sides.
module pipelined_xor_accum
  import pipelined_xor_accum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             in_last,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] x_comb;

  logic [WIDTH-1:0] x_p1_q;
  mode_e            mode_p1_q;
  logic             last_p1_q;
  logic             vld_p1_q, vld_p1_d;

  logic [WIDTH-1:0] out_p2_q, out_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             parity_p2_q, parity_p2_d;
  logic [CNT_W-1:0] beats_p2_q, beats_p2_d;
  logic             vld_p2_q, vld_p2_d;

  logic [WIDTH-1:0] acc_q, acc_d, acc_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  // An unconsumed result freezes the whole pipeline.
  assign stall    = vld_p2_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  xor_stage #(
    .WIDTH(WIDTH)
  ) u_xor_stage (
    .a_i(a),
    .b_i(b),
    .x_o(x_comb)
  );

  // ---- stage 1: register operand XOR and beat attributes ----
  assign vld_p1_d = stall ? vld_p1_q : accept;

  always_ff @(posedge clk) begin
    if (accept) begin
      x_p1_q    <= x_comb;
      mode_p1_q <= mode_e'(mode);
      last_p1_q <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  // ---- stage 2: pass-through load, frame fold, or frame emit ----
  always_comb begin
    // A clear retires the open frame first, so a colliding beat starts afresh.
    acc_base    = acc_clear ? '0 : acc_q;
    cnt_base    = acc_clear ? '0 : cnt_q;
    acc_d       = acc_base;
    cnt_d       = cnt_base;
    out_p2_d    = out_p2_q;
    beats_p2_d  = beats_p2_q;
    vld_p2_d    = vld_p2_q;
    if (!stall) begin
      vld_p2_d = 1'b0;
      if (vld_p1_q) begin
        if (mode_p1_q == MODE_XOR) begin
          out_p2_d   = x_p1_q;
          beats_p2_d = CNT_ONE;
          vld_p2_d   = 1'b1;
        end else if (last_p1_q) begin
          out_p2_d   = acc_base ^ x_p1_q;
          beats_p2_d = sat_inc(cnt_base);
          vld_p2_d   = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
        end else begin
          acc_d = acc_base ^ x_p1_q;
          cnt_d = sat_inc(cnt_base);
        end
      end
    end
    zero_p2_d   = ~|out_p2_d;
    parity_p2_d = ^out_p2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p2_q    <= '0;
      zero_p2_q   <= 1'b1;
      parity_p2_q <= 1'b0;
      beats_p2_q  <= '0;
      vld_p2_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_p2_q    <= out_p2_d;
      zero_p2_q   <= zero_p2_d;
      parity_p2_q <= parity_p2_d;
      beats_p2_q  <= beats_p2_d;
      vld_p2_q    <= vld_p2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out        = out_p2_q;
  assign out_zero   = zero_p2_q;
  assign out_parity = parity_p2_q;
  assign out_beats  = beats_p2_q;
  assign out_valid  = vld_p2_q;

endmodule

// File: tb/tb_pipelined_xor_accum.sv
// Scoreboard bench for pipelined_xor_accum: directed beats push expected
// results; per-DUT monitors pop and compare on each output handshake.
module tb_pipelined_xor_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        use2;
  logic [13:0] a, b;
  logic        mode, in_last, acc_clear, out_ready;

  logic        in_ready1, out_valid1, out_zero1, out_parity1;
  logic [13:0] out1;
  logic [7:0]  out_beats1;
  logic        in_ready2, out_valid2, out_zero2, out_parity2;
  logic [13:0] out2;
  logic [1:0]  out_beats2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [13:0] o;
    logic        z;
    logic        p;
    logic [7:0]  n;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  pipelined_xor_accum #(.WIDTH(14), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~use2), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
    .out_zero(out_zero1), .out_parity(out_parity1), .out_beats(out_beats1)
  );

  pipelined_xor_accum #(.WIDTH(14), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & use2), .in_ready(in_ready2),
    .a(a), .b(b), .mode(mode), .in_last(in_last), .acc_clear(acc_clear),
    .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
    .out_zero(out_zero2), .out_parity(out_parity2), .out_beats(out_beats2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void push1(input logic [13:0] o, input logic z, input logic p, input logic [7:0] n);
    exp_t e;
    e.o = o; e.z = z; e.p = p; e.n = n;
    q1.push_back(e);
  endfunction

  function automatic void push2(input logic [13:0] o, input logic z, input logic p, input logic [7:0] n);
    exp_t e;
    e.o = o; e.z = z; e.p = p; e.n = n;
    q2.push_back(e);
  endfunction

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [13:0] av, input logic [13:0] bv,
                      input logic m, input logic l, input logic sel2);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    a = av; b = bv; mode = m; in_last = l; use2 = sel2; in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = sel2 ? in_ready2 : in_ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out1: got out=%0h, expected no output", out1);
      end else begin
        e = q1.pop_front();
        check("out1", out1, e.o);
        check("out_zero1", out_zero1, e.z);
        check("out_parity1", out_parity1, e.p);
        check("out_beats1", out_beats1, e.n);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out2: got out=%0h, expected no output", out2);
      end else begin
        e = q2.pop_front();
        check("out2", out2, e.o);
        check("out_zero2", out_zero2, e.z);
        check("out_parity2", out_parity2, e.p);
        check("out_beats2", out_beats2, e.n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b1; use2 = 1'b0;
    a = 14'h1234; b = 14'h0000; mode = 1'b0; in_last = 1'b1;
    acc_clear = 1'b0; out_ready = 1'b1;

    // Reset state, with a beat offered throughout
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", out1, 14'h0000);
    check("rst_zero", out_zero1, 1'b1);
    check("rst_parity", out_parity1, 1'b0);
    check("rst_beats", out_beats1, 8'd0);
    check("rst_valid", out_valid1, 1'b0);
    check("rst_in_ready", in_ready1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_discard", out_valid1, 1'b0);
    @(posedge clk); #1;

    // Pass-through with latency check
    push1(14'h3FFE, 1'b0, 1'b1, 8'd1);
    send(14'h3FFF, 14'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_c1", out_valid1, 1'b0);
    @(negedge clk);
    check("latency_c2", out_valid1, 1'b1);
    @(posedge clk); #1;

    // Three-beat frame
    push1(14'h1111, 1'b0, 1'b0, 8'd3);
    send(14'h0013, 14'h0002, 1'b1, 1'b0, 1'b0);
    send(14'h0101, 14'h0000, 1'b1, 1'b0, 1'b0);
    send(14'h1000, 14'h0001, 1'b1, 1'b1, 1'b0);

    // Pass-through beat interleaved inside an open frame
    push1(14'h2001, 1'b0, 1'b0, 8'd1);
    push1(14'h0033, 1'b0, 1'b0, 8'd2);
    send(14'h0030, 14'h0000, 1'b1, 1'b0, 1'b0);
    send(14'h2000, 14'h0001, 1'b0, 1'b0, 1'b0);
    send(14'h0003, 14'h0000, 1'b1, 1'b1, 1'b0);

    // Continuous stream with a 5-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          push1(14'(i * 291 + 1) ^ 14'h2AAA, ~|(14'(i * 291 + 1) ^ 14'h2AAA),
                ^(14'(i * 291 + 1) ^ 14'h2AAA), 8'd1);
          send(14'(i * 291 + 1), 14'h2AAA, 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready1, 1'b0);
          check("stall_out_valid", out_valid1, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // Clear collides with the last beat of an open frame (acc = 00FF)
    send(14'h00F0, 14'h0000, 1'b1, 1'b0, 1'b0);
    send(14'h000F, 14'h0000, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    push1(14'h0003, 1'b0, 1'b0, 8'd1);
    send(14'h0003, 14'h0000, 1'b1, 1'b1, 1'b0);
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Asynchronous reset in the middle of an unterminated frame
    send(14'h0055, 14'h0000, 1'b1, 1'b0, 1'b0);
    send(14'h0AA0, 14'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out1, 14'h0000);
    check("async_rst_zero", out_zero1, 1'b1);
    check("async_rst_beats", out_beats1, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push1(14'h0000, 1'b1, 1'b0, 8'd1);
    send(14'h1555, 14'h1555, 1'b1, 1'b1, 1'b0);

    // Beat-count saturation on the CNT_W=2 instance
    push2(14'h003E, 1'b0, 1'b1, 8'd3);
    send(14'h0001, 14'h0000, 1'b1, 1'b0, 1'b1);
    send(14'h0002, 14'h0000, 1'b1, 1'b0, 1'b1);
    send(14'h0004, 14'h0000, 1'b1, 1'b0, 1'b1);
    send(14'h0008, 14'h0000, 1'b1, 1'b0, 1'b1);
    send(14'h0010, 14'h0000, 1'b1, 1'b0, 1'b1);
    send(14'h0021, 14'h0000, 1'b1, 1'b1, 1'b1);
    use2 = 1'b0;

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(q1.size() + q2.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_xor_accum.md
PIPELINED_XOR_ACCUM -- requirements
Module: pipelined_xor_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 14, the operand and result width (legal 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, the frame beat-counter width (legal 2..16).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each, the operand vectors.
REQ-008 SHALL have port mode, input, 1 bit: 0 = pass-through XOR, 1 = accumulate frame.
REQ-009 SHALL have port in_last, input, 1 bit, the final beat of an accumulate frame (ignored when mode=0).
REQ-010 SHALL have port acc_clear, input, 1 bit, a synchronous clear of the open accumulate frame.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-013 SHALL have port out, output, WIDTH bits, the XOR result or folded syndrome.
REQ-014 SHALL have port out_zero, output, 1 bit, set when out == 0 (no-error syndrome).
REQ-015 SHALL have port out_parity, output, 1 bit, the XOR-reduction of out.
REQ-016 SHALL have port out_beats, output, CNT_W bits, the number of beats folded into out.

Function
REQ-017 SHALL define the stall as stall = out_valid && !out_ready, with in_ready = !stall; a beat is accepted when in_valid && in_ready.
REQ-018 Stage 1 SHALL register x = a ^ b bitwise, plus mode, in_last and valid, on each accepted beat; when not stalled with no beat, the stage-1 valid bit SHALL be 0.
REQ-019 During a stall, both stages SHALL hold all registers unchanged and SHALL drop no data.
REQ-020 Stage 2, with mode=0, SHALL load out=x, out_beats=1 and out_valid=1; the accumulator SHALL be untouched, so a pass-through beat MAY interleave an open frame.
REQ-021 Stage 2, with mode=1 and in_last=0, SHALL set acc <= acc ^ x and increment beat count (saturating at 2^CNT_W-1), with no output.
REQ-022 Stage 2, with mode=1 and in_last=1, SHALL load out = acc ^ x and out_beats = count+1 (saturating) and set out_valid=1; acc and count SHALL then return to 0.
REQ-023 Latency SHALL be exactly 2 cycles from acceptance of the producing beat to out_valid, absent a stall; throughput SHALL be 1 beat/cycle.
REQ-024 out_valid SHALL clear on the cycle after a handshake unless a new result loads in the same cycle.
REQ-025 out_zero and out_parity SHALL be registered together with out and SHALL be consistent with out on every cycle.
REQ-026 acc_clear SHALL zero acc and count at the next edge; if the stage-2 beat in that cycle is mode=1, it SHALL start a fresh frame (acc = x, count = 1, or emit x with out_beats=1 if last).
REQ-027 acc_clear SHALL have no effect on out, out_valid or stage 1.
REQ-028 When WIDTH=1 the block SHALL still function, with out_parity == out.

Reset
REQ-029 rst_n low SHALL immediately force out=0, out_zero=1, out_parity=0, out_beats=0, out_valid=0, stage-1 valid=0, acc=0 and count=0.
REQ-030 in_ready SHALL read 1 during reset; beats offered during reset SHALL be discarded.
REQ-031 Reset mid-frame SHALL discard the partial frame, with no output produced for it.

Structure
REQ-032 A shared package SHALL hold the mode encodings (MODE_XOR=0, MODE_ACC=1) and the default WIDTH/CNT_W constants.
REQ-033 One sub-module, xor_stage, SHALL implement the parametrised bitwise XOR; it SHALL be the combinational successor of the 14-bit XOR, instantiated in stage 1.

Verification
REQ-034 Pass-through: WIDTH=14, a=14'h3FFF, b=14'h0001, mode=0, out_ready=1 -> 2 cycles later out=14'h3FFE, out_zero=0, out_parity=1, out_beats=1.
REQ-035 Frame: beats (a^b) = 14'h0011, 14'h0101, 14'h1001 with last on beat 3 -> a single output out=14'h1111, out_beats=3, out_parity=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles with a continuous input stream -> in_ready=0 from the stall onward, and results appear in order with none lost or duplicated.
REQ-037 Clear collision: open frame acc=14'h00FF, then acc_clear together with a last beat x=14'h0003 -> out=14'h0003, out_beats=1.
REQ-038 Reset mid-frame: two unterminated beats, rst_n pulse, then a one-beat frame x=0 -> out=0, out_zero=1, out_beats=1.
REQ-039 Saturation: CNT_W=2, a 6-beat frame -> out_beats=3, and out equals the XOR of all 6 beats.
